// File: rtl/fwd_scoreboard.sv
// Hazard/forwarding scoreboard. It tracks the youngest in-flight writer of each
// architectural register (GPRs plus HI at index 32 and LO at index 33) and resolves forwarding
// and stalls for the decode read ports.
// Latency: lookup outputs are combinational (zero cycles); the tracking state updates on the clk edge.
// Backpressure: stall_o blocks issue. While advance_i is low, all state holds and no issue is accepted.
// Ports: clk/reset (synchronous, active-high); advance_i; issue_valid_i/dst/lat; flush_i/flush_age_i;
//        rd_valid_i/rd_addr_i/rf_data_i per read port; stage_data_i per post-decode stage;
//        fwd_sel_o/operand_o per read port; stall_o; issue_accept_o.
module fwd_scoreboard #(
  parameter  int NREG   = 34,
  parameter  int NREAD  = 2,
  parameter  int NSTAGE = 3,
  localparam int AW     = $clog2(NREG),
  localparam int SW     = $clog2(NSTAGE + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                advance_i,
  input  logic                issue_valid_i,
  input  logic [AW-1:0]       issue_dst_i,
  input  logic [SW-1:0]       issue_lat_i,
  input  logic                flush_i,
  input  logic [SW-1:0]       flush_age_i,
  input  logic [NREAD-1:0]    rd_valid_i,
  input  logic [NREAD*AW-1:0] rd_addr_i,
  input  logic [NREAD*32-1:0] rf_data_i,
  input  logic [NSTAGE*32-1:0] stage_data_i,
  output logic [NREAD*SW-1:0] fwd_sel_o,
  output logic [NREAD*32-1:0] operand_o,
  output logic                stall_o,
  output logic                issue_accept_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [SW-1:0]   age_q [NREG];
  logic [SW-1:0]   age_d [NREG];
  logic [SW-1:0]   rdy_q [NREG];
  logic [SW-1:0]   rdy_d [NREG];

  logic [AW-1:0]    addr_w [NREAD];
  logic [SW-1:0]    sel_w  [NREAD];
  logic [31:0]      op_w   [NREAD];
  logic [NREAD-1:0] hazard_w;
  logic [SW-1:0]    lat_clamped;

  genvar g;
  generate
    for (g = 0; g < NREAD; g++) begin : g_port
      assign addr_w[g]                = rd_addr_i[g*AW +: AW];
      assign fwd_sel_o[g*SW +: SW]    = sel_w[g];
      assign operand_o[g*32 +: 32]    = op_w[g];
    end
  endgenerate

  // Lookup: a busy entry forwards once its age has reached its ready age; before that it is a hazard.
  // Index 0 is never forwarded, even though issue never marks it busy.
  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      sel_w[i]    = '0;
      op_w[i]     = rf_data_i[i*32 +: 32];
      hazard_w[i] = 1'b0;
      if (rd_valid_i[i] && (addr_w[i] != '0) && (int'(addr_w[i]) < NREG)) begin
        if (busy_q[addr_w[i]]) begin
          if (age_q[addr_w[i]] >= rdy_q[addr_w[i]]) begin
            sel_w[i] = age_q[addr_w[i]];
            op_w[i]  = stage_data_i[32*(int'(age_q[addr_w[i]]) - 1) +: 32];
          end else begin
            hazard_w[i] = 1'b1;
          end
        end
      end
    end
  end

  assign stall_o        = |hazard_w;
  assign issue_accept_o = issue_valid_i & ~stall_o & advance_i & ~flush_i;

  // A latency of 0 is treated as 1; anything above the last stage becomes the last stage.
  always_comb begin
    lat_clamped = issue_lat_i;
    if (issue_lat_i == '0)              lat_clamped = SW'(1);
    else if (issue_lat_i > SW'(NSTAGE)) lat_clamped = SW'(NSTAGE);
  end

  // Next state: flush squashes young entries; advance ages the rest and retires entries at writeback.
  // The issue write comes last, so a new writer replaces an older copy of the same register.
  always_comb begin
    busy_d = busy_q;
    age_d  = age_q;
    rdy_d  = rdy_q;
    for (int r = 0; r < NREG; r++) begin
      if (busy_q[r]) begin
        if (flush_i && (age_q[r] <= flush_age_i)) begin
          busy_d[r] = 1'b0;
          age_d[r]  = '0;
          rdy_d[r]  = '0;
        end else if (advance_i) begin
          if (age_q[r] == SW'(NSTAGE)) begin
            busy_d[r] = 1'b0;
            age_d[r]  = '0;
            rdy_d[r]  = '0;
          end else begin
            age_d[r] = age_q[r] + SW'(1);
          end
        end
      end
    end
    if (issue_accept_o && (issue_dst_i != '0) && (int'(issue_dst_i) < NREG)) begin
      busy_d[issue_dst_i] = 1'b1;
      age_d[issue_dst_i]  = SW'(1);
      rdy_d[issue_dst_i]  = lat_clamped;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      for (int r = 0; r < NREG; r++) begin
        age_q[r] <= '0;
        rdy_q[r] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      age_q  <= age_d;
      rdy_q  <= rdy_d;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard with default parameters (34 regs, 2 read ports, 3 stages).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_fwd_scoreboard;
  logic        clk;
  logic        reset;
  logic        advance;
  logic        issue_valid;
  logic [5:0]  issue_dst;
  logic [1:0]  issue_lat;
  logic        flush;
  logic [1:0]  flush_age;
  logic [1:0]  rd_valid;
  logic [11:0] rd_addr;
  logic [63:0] rf_data;
  logic [95:0] stage_data;
  logic [3:0]  fwd_sel;
  logic [63:0] operand;
  logic        stall;
  logic        issue_accept;

  int total = 0;
  int bad   = 0;

  fwd_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .advance_i     (advance),
    .issue_valid_i (issue_valid),
    .issue_dst_i   (issue_dst),
    .issue_lat_i   (issue_lat),
    .flush_i       (flush),
    .flush_age_i   (flush_age),
    .rd_valid_i    (rd_valid),
    .rd_addr_i     (rd_addr),
    .rf_data_i     (rf_data),
    .stage_data_i  (stage_data),
    .fwd_sel_o     (fwd_sel),
    .operand_o     (operand),
    .stall_o       (stall),
    .issue_accept_o(issue_accept)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    advance     = 1'b0;
    issue_valid = 1'b0;
    issue_dst   = '0;
    issue_lat   = 2'd1;
    flush       = 1'b0;
    flush_age   = '0;
    rd_valid    = '0;
    rd_addr     = '0;
    rf_data     = {32'hAAAA_0001, 32'hAAAA_0000};
    stage_data  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic issue(input logic [5:0] dst, input logic [1:0] lat);
    idle();
    advance     = 1'b1;
    issue_valid = 1'b1;
    issue_dst   = dst;
    issue_lat   = lat;
  endtask

  task automatic read2(input logic [5:0] a0, input logic [5:0] a1);
    rd_valid = 2'b11;
    rd_addr  = {a1, a0};
  endtask

  task automatic test_reset();
    do_reset();
    read2(6'd5, 6'd33);
    issue_valid = 1'b1;
    issue_dst   = 6'd2;
    advance     = 1'b1;
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    total++; if (fwd_sel !== 4'h0) begin bad++; $display("FAIL reset_fwd_sel got=%h exp=0", fwd_sel); end
    total++; if (operand !== 64'hAAAA_0001_AAAA_0000) begin bad++; $display("FAIL reset_operand got=%h exp=AAAA0001AAAA0000", operand); end
    total++; if (issue_accept !== 1'b1) begin bad++; $display("FAIL reset_accept got=%0b exp=1", issue_accept); end
  endtask

  task automatic test_alu_chain();
    do_reset();
    issue(6'd5, 2'd1);
    step();
    idle();
    read2(6'd5, 6'd5);
    stage_data[31:0] = 32'h0000_1234;
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%0b exp=0", stall); end
    total++; if (fwd_sel !== 4'b0101) begin bad++; $display("FAIL alu_fwd_sel got=%b exp=0101", fwd_sel); end
    total++; if (operand !== {32'h0000_1234, 32'h0000_1234}) begin bad++; $display("FAIL alu_operand got=%h exp=0000123400001234", operand); end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(6'd7, 2'd2);
    step();
    issue(6'd10, 2'd1);
    read2(6'd7, 6'd10);
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b exp=1", stall); end
    total++; if (issue_accept !== 1'b0) begin bad++; $display("FAIL lu_accept got=%0b exp=0", issue_accept); end
    total++; if (fwd_sel[1:0] !== 2'd0) begin bad++; $display("FAIL lu_sel_hazard got=%0d exp=0", fwd_sel[1:0]); end
    step();
    idle();
    read2(6'd7, 6'd10);
    stage_data[63:32] = 32'h0000_5555;
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_clear got=%0b exp=0", stall); end
    total++; if (fwd_sel !== 4'b0010) begin bad++; $display("FAIL lu_fwd_sel got=%b exp=0010", fwd_sel); end
    total++; if (operand !== {32'hAAAA_0001, 32'h0000_5555}) begin bad++; $display("FAIL lu_operand got=%h exp=AAAA000100005555", operand); end
  endtask

  task automatic test_retire_hold();
    logic [1:0]  exp_sel [3];
    logic [31:0] exp_op  [3];
    exp_sel[0] = 2'd2; exp_op[0] = 32'h0000_0200;
    exp_sel[1] = 2'd3; exp_op[1] = 32'h0000_0300;
    exp_sel[2] = 2'd0; exp_op[2] = 32'hAAAA_0000;
    do_reset();
    issue(6'd9, 2'd1);
    step();
    for (int c = 0; c < 5; c++) begin
      idle();
      issue_valid = 1'b1;
      issue_dst   = 6'd11;
      rd_valid    = 2'b01;
      rd_addr     = {6'd0, 6'd9};
      @(negedge clk);
      total++; if (fwd_sel[1:0] !== 2'd1) begin bad++; $display("FAIL hold_sel cyc=%0d got=%0d exp=1", c, fwd_sel[1:0]); end
      total++; if (issue_accept !== 1'b0) begin bad++; $display("FAIL hold_accept cyc=%0d got=%0b exp=0", c, issue_accept); end
      step();
    end
    for (int c = 0; c < 3; c++) begin
      idle();
      advance  = 1'b1;
      rd_valid = 2'b01;
      rd_addr  = {6'd0, 6'd9};
      step();
      idle();
      rd_valid = 2'b01;
      rd_addr  = {6'd0, 6'd9};
      @(negedge clk);
      total++; if (fwd_sel[1:0] !== exp_sel[c]) begin bad++; $display("FAIL retire_sel adv=%0d got=%0d exp=%0d", c + 1, fwd_sel[1:0], exp_sel[c]); end
      total++; if (operand[31:0] !== exp_op[c]) begin bad++; $display("FAIL retire_op adv=%0d got=%h exp=%h", c + 1, operand[31:0], exp_op[c]); end
    end
  endtask

  task automatic test_waw_zero();
    do_reset();
    issue(6'd3, 2'd2);
    step();
    issue(6'd3, 2'd1);
    step();
    issue(6'd0, 2'd1);
    read2(6'd3, 6'd0);
    @(negedge clk);
    total++; if (fwd_sel[1:0] !== 2'd1) begin bad++; $display("FAIL waw_sel got=%0d exp=1", fwd_sel[1:0]); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL waw_stall got=%0b exp=0", stall); end
    total++; if (issue_accept !== 1'b1) begin bad++; $display("FAIL zero_accept got=%0b exp=1", issue_accept); end
    step();
    issue(6'd12, 2'd0);
    read2(6'd0, 6'd3);
    @(negedge clk);
    total++; if (fwd_sel !== 4'b1000) begin bad++; $display("FAIL zero_sel got=%b exp=1000", fwd_sel); end
    total++; if (operand[31:0] !== 32'hAAAA_0000) begin bad++; $display("FAIL zero_op got=%h exp=AAAA0000", operand[31:0]); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL zero_stall got=%0b exp=0", stall); end
    step();
    idle();
    read2(6'd12, 6'd3);
    @(negedge clk);
    total++; if (fwd_sel !== 4'b1101) begin bad++; $display("FAIL lat0_sel got=%b exp=1101", fwd_sel); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lat0_stall got=%0b exp=0", stall); end
  endtask

  task automatic test_flush();
    do_reset();
    issue(6'd6, 2'd1); step();
    issue(6'd5, 2'd1); step();
    issue(6'd4, 2'd1); step();
    idle();
    read2(6'd6, 6'd4);
    @(negedge clk);
    total++; if (fwd_sel !== 4'b0111) begin bad++; $display("FAIL pre_flush_sel got=%b exp=0111", fwd_sel); end
    issue(6'd8, 2'd1);
    flush     = 1'b1;
    flush_age = 2'd2;
    #1;
    total++; if (issue_accept !== 1'b0) begin bad++; $display("FAIL flush_accept got=%0b exp=0", issue_accept); end
    step();
    idle();
    read2(6'd4, 6'd5);
    @(negedge clk);
    total++; if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL flush_sel_45 got=%b exp=0000", fwd_sel); end
    read2(6'd6, 6'd8);
    #1;
    total++; if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL flush_sel_68 got=%b exp=0000", fwd_sel); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0b exp=0", stall); end
    // Flush without advance: survivors keep their age.
    do_reset();
    issue(6'd5, 2'd1); step();
    issue(6'd4, 2'd1); step();
    idle();
    flush     = 1'b1;
    flush_age = 2'd1;
    step();
    idle();
    read2(6'd5, 6'd4);
    @(negedge clk);
    total++; if (fwd_sel !== 4'b0010) begin bad++; $display("FAIL flush_hold_sel got=%b exp=0010", fwd_sel); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(6'd1, 2'd3); step();
    issue(6'd2, 2'd3); step();
    issue(6'd3, 2'd3); step();
    idle();
    read2(6'd2, 6'd3);
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL mid_pre_stall got=%0b exp=1", stall); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mid_stall got=%0b exp=0", stall); end
    total++; if (fwd_sel !== 4'h0) begin bad++; $display("FAIL mid_sel got=%b exp=0000", fwd_sel); end
    total++; if (operand !== 64'hAAAA_0001_AAAA_0000) begin bad++; $display("FAIL mid_op got=%h exp=AAAA0001AAAA0000", operand); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_alu_chain();
    test_load_use();
    test_retire_hold();
    test_waw_zero();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
Parametrised hazard/forwarding scoreboard that succeeds the ad-hoc compare-and-stall logic inside the decode stage. It tracks, per architectural register (GPRs plus HI/LO), the youngest in-flight writer, its pipeline age and the age at which its result becomes forwardable. For NREAD decode read ports it produces forward-select, forwarded operand and a global stall. It sits beside decode and is updated on every pipeline advance.

Parameters:
NREG, 34, tracked registers; index 0 = $zero (never busy), 32 = HI, 33 = LO
NREAD, 2, number of decode read ports
NSTAGE, 3, post-decode stages holding results (1=execute, 2=memory, 3=writeback)
AW, $clog2(NREG), register index width (derived)
SW, $clog2(NSTAGE+1), age / forward-select width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
advance  in  1  pipeline moves one stage this cycle
issue_valid  in  1  decode presents a writing instruction
issue_dst  in  AW  destination register of issuing instruction
issue_lat  in  SW  age at which result is forwardable (1..NSTAGE)
flush  in  1  squash young in-flight writers
flush_age  in  SW  entries with age <= flush_age are squashed
rd_valid  in  NREAD  per-port read enable
rd_addr  in  NREAD*AW  per-port source register
rf_data  in  NREAD*32  per-port register-file read data
stage_data  in  NSTAGE*32  result of stage k at slice k-1
fwd_sel  out  NREAD*SW  0 = register file, k = stage k
operand  out  NREAD*32  forwarded operand per port
stall  out  1  decode must hold; issue not accepted
issue_accept  out  1  issue_valid & ~stall & advance & ~flush

Behaviour:
- Clock is clk; reset is synchronous active-high; both fixed.
- State per register r: busy[r], age[r] (SW bits), rdy[r] (SW bits). Reset: all busy=0, age=0, rdy=0 → stall=0, fwd_sel=0, operand=rf_data.
- Lookup (combinational), port i: if !rd_valid[i], rd_addr=0, or !busy: fwd_sel=0, operand=rf_data[i], no hazard. If busy and age>=rdy: fwd_sel=age, operand=stage_data[age-1]. If busy and age<rdy: hazard; fwd_sel=0.
- stall = OR of port hazards. Zero-cycle latency to outputs.
- Update on rising edge, in priority order:
  1. reset: clear all.
  2. flush: busy entries with age<=flush_age cleared; rest age+1 if advance; issue dropped.
  3. advance: every busy entry age+1; entry with age==NSTAGE clears (retired at writeback).
  4. issue_accept and issue_dst!=0: entry[dst] <= busy=1, age=1, rdy=clamp(issue_lat,1,NSTAGE). Overrides step 3 for same register (WAW: youngest writer wins; older copy untracked).
- advance=0: all state holds; issue never accepted.
- issue_dst=0: accepted (pipeline advances) but no entry written.
- issue_lat=0 treated as 1; >NSTAGE treated as NSTAGE.
- HI/LO handled identically to GPRs at indices 32/33; MADD-type ops issue one entry per written register (one per cycle; decode splits or sets both via two ports in future revision — not in scope).
- Same register on multiple ports: each port resolved independently, identical result.
- No busy bit for age 0; decode-stage instruction never forwards to itself.

Test Plan:
- ALU chain: issue dst=5 lat=1, advance; next cycle rd_addr[0]=5, stage_data[0]=0x1234 → stall=0, fwd_sel[0]=1, operand[0]=0x1234.
- Load-use: issue dst=7 lat=2, advance; read 7 → stall=1, issue_accept=0; advance once more → stall=0, fwd_sel=2, operand=stage_data[1].
- Retire/hold: issue dst=9 lat=1; advance=0 for 5 cycles → fwd_sel stays 1; then 3 advances → fwd_sel=0, operand=rf_data.
- WAW + $zero: issue dst=3 lat=2, then dst=3 lat=1; read 3 → fwd_sel=1, stall=0; issue dst=0 then read 0 → fwd_sel=0, stall=0.
- Flush: writers at ages 1,2,3 (regs 4,5,6); flush=1 flush_age=2 with advance and issue dst=8 → next cycle only reg 6 tracked... retired (age 3→clear), regs 4,5,8 untracked, all fwd_sel=0.
- Reset mid-operation: 3 busy entries with stall=1; assert reset one cycle → next cycle stall=0, all fwd_sel=0.
